// File: rtl/qpi_psram_responder.sv
// QPI PSRAM responder: decodes SPI QPI-enable and QPI read/write/exit frames
// against an internal byte array. Requires 4 <= ADDR_BITS <= 24 and WAITCYCLES >= 1.
module qpi_psram_responder #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned WAITCYCLES = 6,
    parameter logic [7:0]  CMD_QPI_EN = 8'h35,
    parameter logic [7:0]  CMD_QPI_EX = 8'hF5,
    parameter logic [7:0]  CMD_READ   = 8'hEB,
    parameter logic [7:0]  CMD_WRITE  = 8'h38
) (
    input  logic       i_clkRAM,
    input  logic       reset,
    input  logic       i_psram_cs,
    inout  wire  [3:0] io_psram_data,
    output logic       o_qpi_mode,
    output logic       o_busy,
    output logic       o_err
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = $clog2(8 + WAITCYCLES + 1);
    localparam logic [CNT_W-1:0] K_LAST_HDR  = CNT_W'(7);
    localparam logic [CNT_W-1:0] K_LAST_WAIT = CNT_W'(7 + WAITCYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_SPI_CMD, S_QPI_CMD, S_ADDR, S_WAIT, S_RD_DATA, S_WR_DATA, S_IGNORE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [6:0]           cmd_q, cmd_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [3:0]           hi_q, hi_d;
    logic [3:0]           dout_q, dout_d;
    logic                 half_q, half_d;
    logic                 is_wr_q, is_wr_d;
    logic                 qpi_q, qpi_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 drv_q, drv_d;
    logic                 mem_we_c;
    logic [7:0]           rd_byte_c;
    logic [7:0]           spi_byte_c;
    logic [7:0]           qpi_byte_c;

    logic [7:0] mem [DEPTH];

    assign rd_byte_c  = mem[ptr_q];
    assign spi_byte_c = {cmd_q, io_psram_data[0]};
    assign qpi_byte_c = {cmd_q[3:0], io_psram_data};

    // Next-state and datapath; CS high overrides every transition.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        ptr_d    = ptr_q;
        hi_d     = hi_q;
        dout_d   = dout_q;
        half_d   = half_q;
        is_wr_d  = is_wr_q;
        qpi_d    = qpi_q;
        busy_d   = 1'b1;
        err_d    = 1'b0;
        drv_d    = drv_q;
        mem_we_c = 1'b0;
        if (i_psram_cs) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            drv_d   = 1'b0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            unique case (state_q)
                S_IDLE: begin
                    cnt_d  = CNT_W'(1);
                    half_d = 1'b0;
                    drv_d  = 1'b0;
                    if (qpi_q) begin
                        state_d = S_QPI_CMD;
                        cmd_d   = {3'b000, io_psram_data};
                    end else begin
                        state_d = S_SPI_CMD;
                        cmd_d   = {6'b000000, io_psram_data[0]};
                    end
                end
                S_SPI_CMD: begin
                    cmd_d = {cmd_q[5:0], io_psram_data[0]};
                    if (cnt_q == K_LAST_HDR) begin
                        state_d = S_IGNORE;
                        if (spi_byte_c == CMD_QPI_EN) qpi_d = 1'b1;
                        else                          err_d = 1'b1;
                    end
                end
                S_QPI_CMD: begin
                    if (qpi_byte_c == CMD_READ) begin
                        state_d = S_ADDR;
                        is_wr_d = 1'b0;
                    end else if (qpi_byte_c == CMD_WRITE) begin
                        state_d = S_ADDR;
                        is_wr_d = 1'b1;
                    end else if (qpi_byte_c == CMD_QPI_EX) begin
                        state_d = S_IGNORE;
                        qpi_d   = 1'b0;
                    end else begin
                        state_d = S_IGNORE;
                        err_d   = 1'b1;
                    end
                end
                S_ADDR: begin
                    // Upper address nibbles shift out of the pointer.
                    ptr_d = {ptr_q[ADDR_BITS-5:0], io_psram_data};
                    if (cnt_q == K_LAST_HDR) state_d = is_wr_q ? S_WR_DATA : S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == K_LAST_WAIT) begin
                        state_d = S_RD_DATA;
                        drv_d   = 1'b1;
                        dout_d  = rd_byte_c[7:4];
                        half_d  = 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (half_q) begin
                        dout_d = rd_byte_c[3:0];
                        ptr_d  = ptr_q + ADDR_BITS'(1);
                        half_d = 1'b0;
                    end else begin
                        dout_d = rd_byte_c[7:4];
                        half_d = 1'b1;
                    end
                end
                S_WR_DATA: begin
                    if (half_q) begin
                        mem_we_c = 1'b1;
                        ptr_d    = ptr_q + ADDR_BITS'(1);
                        half_d   = 1'b0;
                    end else begin
                        hi_d   = io_psram_data;
                        half_d = 1'b1;
                    end
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clkRAM or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            ptr_q   <= '0;
            hi_q    <= '0;
            dout_q  <= '0;
            half_q  <= 1'b0;
            is_wr_q <= 1'b0;
            qpi_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            ptr_q   <= ptr_d;
            hi_q    <= hi_d;
            dout_q  <= dout_d;
            half_q  <= half_d;
            is_wr_q <= is_wr_d;
            qpi_q   <= qpi_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            drv_q   <= drv_d;
        end
    end

    // Array is deliberately not cleared by reset.
    always_ff @(posedge i_clkRAM) begin
        if (mem_we_c) mem[ptr_q] <= {hi_q, io_psram_data};
    end

    assign io_psram_data = (drv_q && !i_psram_cs) ? dout_q : 4'bzzzz;
    assign o_qpi_mode    = qpi_q;
    assign o_busy        = busy_q;
    assign o_err         = err_q;

endmodule
